// File: rtl/alu_result_queue.sv
// Registered result FIFO behind the 16-bit ALU, with a flag register and a saturating overflow counter.
// Optional sticky overflow flag is enabled by defining ALU_STICKY_OVF_EN.
module alu_result_queue #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_z,
   input  logic [4:0]               in_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_z,
   output logic [4:0]               out_flags,
   output logic [4:0]               flags_q,
   output logic [7:0]               ovf_cnt,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     clr_sticky,
   output logic                     ovf_sticky
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = WIDTH + 5;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [AW:0]   wr_ptr, rd_ptr;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic          full, empty, push, pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign push  = in_valid && !full;
   assign pop   = out_ready && !empty;

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign level     = wr_ptr - rd_ptr;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign out_z     = empty ? '0 : head[EW-1:5];
   assign out_flags = empty ? '0 : head[4:0];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_z, in_flags};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         flags_q <= '0;
         ovf_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            flags_q <= in_flags;
            if (in_flags[0]) ovf_cnt <= sat_inc8(ovf_cnt);
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

`ifdef ALU_STICKY_OVF_EN
   // Set has priority over clear so an overflow in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     ovf_sticky <= 1'b0;
      else if (push && in_flags[0])   ovf_sticky <= 1'b1;
      else if (clr_sticky)            ovf_sticky <= 1'b0;
   end
`else
   logic unused_clr_sticky;
   assign unused_clr_sticky = clr_sticky;
   assign ovf_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: vector table plus hand-written multi-cycle sequences.
module tb_alu_result_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_z = '0;
   logic [4:0]  in_flags = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_z;
   logic [4:0]  out_flags;
   logic [4:0]  flags_q;
   logic [7:0]  ovf_cnt;
   logic [2:0]  level;
   logic        clr_sticky = 1'b0;
   logic        ovf_sticky;

`ifdef ALU_STICKY_OVF_EN
   localparam logic STK = 1'b1;
`else
   localparam logic STK = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_result_queue #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
      .flags_q(flags_q), .ovf_cnt(ovf_cnt), .level(level),
      .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
   );

   typedef struct {
      logic        iv;
      logic [15:0] iz;
      logic [4:0]  ifl;
      logic        ordy;
      logic        ov;
      logic [15:0] oz;
      logic [4:0]  ofl;
      logic [2:0]  lvl;
      logic [4:0]  fq;
      logic [7:0]  cnt;
      logic        irdy;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [15:0] iz, input logic [4:0] ifl,
                       input logic ordy, input logic clr);
      in_valid   = iv;
      in_z       = iz;
      in_flags   = ifl;
      out_ready  = ordy;
      clr_sticky = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string nm, input logic ov, input logic [15:0] oz,
                           input logic [4:0] ofl, input logic [2:0] lvl);
      chk({nm, "_valid"}, 32'(out_valid), 32'(ov));
      chk({nm, "_z"},     32'(out_z),     32'(oz));
      chk({nm, "_flags"}, 32'(out_flags), 32'(ofl));
      chk({nm, "_level"}, 32'(level),     32'(lvl));
   endtask

   initial begin
      // in_valid, in_z, in_flags, out_ready | out_valid, out_z, out_flags, level, flags_q, ovf_cnt, in_ready
      vecs[0]  = '{1'b1, 16'h0FFF, 5'b00101, 1'b0, 1'b1, 16'h0FFF, 5'b00101, 3'd1, 5'b00101, 8'd1, 1'b1};
      vecs[1]  = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 16'h0000, 5'b00000, 3'd0, 5'b00101, 8'd1, 1'b1};
      vecs[2]  = '{1'b1, 16'h0000, 5'b01100, 1'b0, 1'b1, 16'h0000, 5'b01100, 3'd1, 5'b01100, 8'd1, 1'b1};
      vecs[3]  = '{1'b1, 16'hFFFF, 5'b10010, 1'b0, 1'b1, 16'h0000, 5'b01100, 3'd2, 5'b10010, 8'd1, 1'b1};
      vecs[4]  = '{1'b1, 16'h1111, 5'b00000, 1'b0, 1'b1, 16'h0000, 5'b01100, 3'd3, 5'b00000, 8'd1, 1'b1};
      vecs[5]  = '{1'b1, 16'h2222, 5'b00001, 1'b0, 1'b1, 16'h0000, 5'b01100, 3'd4, 5'b00001, 8'd2, 1'b0};
      vecs[6]  = '{1'b1, 16'h3333, 5'b11111, 1'b0, 1'b1, 16'h0000, 5'b01100, 3'd4, 5'b00001, 8'd2, 1'b0};
      vecs[7]  = '{1'b1, 16'h4444, 5'b00010, 1'b1, 1'b1, 16'hFFFF, 5'b10010, 3'd3, 5'b00001, 8'd2, 1'b1};
      vecs[8]  = '{1'b1, 16'h4444, 5'b00010, 1'b0, 1'b1, 16'hFFFF, 5'b10010, 3'd4, 5'b00010, 8'd2, 1'b0};
      vecs[9]  = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b1, 16'h1111, 5'b00000, 3'd3, 5'b00010, 8'd2, 1'b1};
      vecs[10] = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b1, 16'h2222, 5'b00001, 3'd2, 5'b00010, 8'd2, 1'b1};
      vecs[11] = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b1, 16'h4444, 5'b00010, 3'd1, 5'b00010, 8'd2, 1'b1};
      vecs[12] = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 16'h0000, 5'b00000, 3'd0, 5'b00010, 8'd2, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_head("rst", 1'b0, 16'h0, 5'h0, 3'd0);
      chk("rst_in_ready", 32'(in_ready), 32'(1'b1));
      chk("rst_flags_q", 32'(flags_q), 32'h0);
      chk("rst_ovf_cnt", 32'(ovf_cnt), 32'h0);
      chk("rst_sticky", 32'(ovf_sticky), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Pass-through, fill/full, push/pop at full, drain
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].iv, vecs[i].iz, vecs[i].ifl, vecs[i].ordy, 1'b0);
         chk_head($sformatf("v%0d", i), vecs[i].ov, vecs[i].oz, vecs[i].ofl, vecs[i].lvl);
         chk($sformatf("v%0d_flags_q", i),  32'(flags_q),  32'(vecs[i].fq));
         chk($sformatf("v%0d_ovf_cnt", i),  32'(ovf_cnt),  32'(vecs[i].cnt));
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].irdy));
      end

      // Wrap-around stream: one push and one pop per cycle
      step(1'b1, 16'hA000, 5'b00000, 1'b0, 1'b0);
      chk_head("wrap0", 1'b1, 16'hA000, 5'b00000, 3'd1);
      for (int i = 1; i < 10; i++) begin
         step(1'b1, 16'hA000 + 16'(i), {i[3:0], 1'b0}, 1'b1, 1'b0);
         chk_head($sformatf("wrap%0d", i), 1'b1, 16'hA000 + 16'(i), {i[3:0], 1'b0}, 3'd1);
         chk($sformatf("wrap%0d_flags_q", i), 32'(flags_q), 32'({i[3:0], 1'b0}));
      end
      step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
      chk_head("wrap_end", 1'b0, 16'h0, 5'h0, 3'd0);
      chk("wrap_ovf_cnt", 32'(ovf_cnt), 32'd2);

      // Overflow saturation and sticky flag
      for (int i = 0; i < 300; i++) step(1'b1, 16'(i), 5'b00001, 1'b1, 1'b0);
      chk("sat_ovf_cnt", 32'(ovf_cnt), 32'd255);
      chk("sat_level", 32'(level), 32'd1);
      chk("sat_sticky", 32'(ovf_sticky), 32'(STK));
      step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
      chk("sat_hold_cnt", 32'(ovf_cnt), 32'd255);
      chk("sat_hold_sticky", 32'(ovf_sticky), 32'(STK));
      step(1'b0, 16'h0, 5'h0, 1'b0, 1'b1);
      chk("clr_sticky", 32'(ovf_sticky), 32'h0);
      step(1'b1, 16'h5555, 5'b00001, 1'b0, 1'b1);
      chk("clr_set_sticky", 32'(ovf_sticky), 32'(STK));
      chk("clr_set_cnt", 32'(ovf_cnt), 32'd255);

      // Asynchronous reset mid-stream
      step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 16'hC000 + 16'(i), 5'b00011, 1'b0, 1'b0);
      chk_head("pre_rst", 1'b1, 16'hC000, 5'b00011, 3'd3);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk_head("async_rst", 1'b0, 16'h0, 5'h0, 3'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'(1'b1));
      chk("async_rst_flags_q", 32'(flags_q), 32'h0);
      chk("async_rst_ovf_cnt", 32'(ovf_cnt), 32'h0);
      chk("async_rst_sticky", 32'(ovf_sticky), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 16'hBEEF, 5'b00100, 1'b0, 1'b0);
      chk_head("post_rst", 1'b1, 16'hBEEF, 5'b00100, 3'd1);
      chk("post_rst_flags_q", 32'(flags_q), 32'(5'b00100));
      chk("post_rst_ovf_cnt", 32'(ovf_cnt), 32'h0);
      step(1'b0, 16'h0, 5'h0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
